// File: rtl/lsu_pkg.sv
// Shared LSU package.
// Holds the common datapath widths, the access-size encoding used by the
// AGU and the load path, and the state type of the misaligned-load merger.
package lsu_pkg;

    localparam int XLEN             = 64;
    localparam int VIRTUAL_ADDR_LEN = 39;
    localparam int ROB_INDEX_WIDTH  = 4;

    // Access size; the number of bytes is 1 << size.
    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_WB    = 3'd5
    } lsu_ld_state_e;

endpackage

// File: rtl/lsu_ld_extend.sv
// Load-value extender.
// Takes a right-justified raw load value, keeps the low 1/2/4/8 bytes given
// by the access size and zero- or sign-extends them to XLEN. A doubleword
// passes through untouched. Purely combinational; shared with the
// store-forwarding path.
//   i_raw      : right-justified raw value (upper bytes are don't-care)
//   i_size     : access size
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : extended value
module lsu_ld_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_raw,
    input  lsu_size_e       i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_size)
            LSU_SIZE_B: o_data = i_unsigned ? {{(XLEN-8){1'b0}}, i_raw[7:0]}
                                            : {{(XLEN-8){i_raw[7]}}, i_raw[7:0]};
            LSU_SIZE_H: o_data = i_unsigned ? {{(XLEN-16){1'b0}}, i_raw[15:0]}
                                            : {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
            LSU_SIZE_W: o_data = i_unsigned ? {{(XLEN-32){1'b0}}, i_raw[31:0]}
                                            : {{(XLEN-32){i_raw[31]}}, i_raw[31:0]};
            default:    o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/lsu_ld_misalign_merge.sv
// Misaligned load merger.
// Accepts one load at a time from the AGU, issues one or two doubleword-
// aligned reads, merges the returned doublewords into a right-justified,
// extended value and presents it for writeback with its ROB tag.
//   clk, rstn                    : clock, synchronous active-low reset
//   req_valid_i/req_ready_o      : load request handshake
//   req_vaddr_i/size/unsigned    : load byte address and attributes
//   req_rob_idx_i                : tag carried to writeback
//   mem_req_valid_o/ready_i/addr : aligned read request to memory
//   mem_resp_valid_i/data_i      : read data, no backpressure
//   wb_valid_o/ready_i/data/rob  : merged result handshake
//
// state    | meaning
// IDLE     | ready for a new load
// REQ0     | requesting the first (or only) doubleword
// WAIT0    | waiting for the first doubleword
// REQ1     | requesting the next doubleword of a split load
// WAIT1    | waiting for the second doubleword
// WB       | holding the merged result until consumed
module lsu_ld_misalign_merge
    import lsu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [VIRTUAL_ADDR_LEN-1:0] req_vaddr_i,
    input  logic [1:0]                  req_size_i,
    input  logic                        req_unsigned_i,
    input  logic [ROB_INDEX_WIDTH-1:0]  req_rob_idx_i,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic [VIRTUAL_ADDR_LEN-1:0] mem_req_addr_o,
    input  logic                        mem_resp_valid_i,
    input  logic [XLEN-1:0]             mem_resp_data_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [XLEN-1:0]             wb_data_o,
    output logic [ROB_INDEX_WIDTH-1:0]  wb_rob_idx_o
);

    lsu_ld_state_e               r_state;
    lsu_ld_state_e               w_next;
    logic [VIRTUAL_ADDR_LEN-1:0] r_addr;
    logic [2:0]                  r_off;
    lsu_size_e                   r_size;
    logic                        r_unsigned;
    logic                        r_split;
    logic [ROB_INDEX_WIDTH-1:0]  r_rob;
    logic [XLEN-1:0]             r_data0;
    logic [XLEN-1:0]             r_wb_data;

    logic                        w_req_split;
    logic [XLEN-1:0]             w_d0;
    logic [XLEN-1:0]             w_shr;
    logic [XLEN-1:0]             w_shl;
    logic [XLEN-1:0]             w_raw;
    logic [XLEN-1:0]             w_ext;
    logic                        w_done;

    assign w_req_split = ({1'b0, req_vaddr_i[2:0]} + (4'd1 << req_size_i)) > 4'd8;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid_i)      w_next = ST_REQ0;
            ST_REQ0:  if (mem_req_ready_i)  w_next = ST_WAIT0;
            ST_WAIT0: if (mem_resp_valid_i) w_next = r_split ? ST_REQ1 : ST_WB;
            ST_REQ1:  if (mem_req_ready_i)  w_next = ST_WAIT1;
            ST_WAIT1: if (mem_resp_valid_i) w_next = ST_WB;
            ST_WB:    if (wb_ready_i)       w_next = ST_IDLE;
            default:                        w_next = ST_IDLE;
        endcase
    end

    // The merge works straight off the response bus so the result can be
    // registered in the same cycle the last doubleword arrives. For an
    // unsplit load the response itself is data0; for a split load the
    // response is data1 and data0 comes from its register.
    assign w_d0  = (r_state == ST_WAIT0) ? mem_resp_data_i : r_data0;
    assign w_shr = w_d0 >> {r_off, 3'b000};
    // Shift of 64 when off=0 yields zero; a split load never has off=0.
    assign w_shl = mem_resp_data_i << (7'd64 - {1'b0, r_off, 3'b000});
    assign w_raw = r_split ? (w_shr | w_shl) : w_shr;

    assign w_done = mem_resp_valid_i &&
                    (((r_state == ST_WAIT0) && !r_split) || (r_state == ST_WAIT1));

    lsu_ld_extend u_extend (
        .i_raw      (w_raw),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_off      <= '0;
            r_size     <= LSU_SIZE_B;
            r_unsigned <= 1'b0;
            r_split    <= 1'b0;
            r_rob      <= '0;
            r_data0    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && req_valid_i) begin
                r_addr     <= {req_vaddr_i[VIRTUAL_ADDR_LEN-1:3], 3'b000};
                r_off      <= req_vaddr_i[2:0];
                r_size     <= lsu_size_e'(req_size_i);
                r_unsigned <= req_unsigned_i;
                r_split    <= w_req_split;
                r_rob      <= req_rob_idx_i;
            end
            if ((r_state == ST_WAIT0) && mem_resp_valid_i) begin
                r_data0 <= mem_resp_data_i;
                // Wraps naturally at the top of the address space.
                if (r_split) r_addr <= r_addr + VIRTUAL_ADDR_LEN'(8);
            end
            if (w_done) r_wb_data <= w_ext;
        end
    end

    assign req_ready_o     = (r_state == ST_IDLE);
    assign mem_req_valid_o = (r_state == ST_REQ0) || (r_state == ST_REQ1);
    assign mem_req_addr_o  = r_addr;
    assign wb_valid_o      = (r_state == ST_WB);
    assign wb_data_o       = r_wb_data;
    assign wb_rob_idx_o    = r_rob;

endmodule

// File: doc/lsu_ld_misalign_merge.md
# lsu_ld_misalign_merge

Load-side companion to the LSU address generator: takes a generated load virtual address plus size/sign attributes, issues one or two 8-byte-aligned memory reads, and merges the returned doublewords into a single right-justified, sign/zero-extended writeback value. It sits between the AGU output and the D-cache/bus read port, and hides misaligned (doubleword-crossing) loads from the rest of the pipeline.

## Interface
- XLEN, 64, data width; merge logic is fixed at 8 bytes per access.
- VIRTUAL_ADDR_LEN, 39, address width.
- ROB_INDEX_WIDTH, 4, tag carried through to writeback.
- clk  in  1  single clock, all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- req_valid_i  in  1  load request valid.
- req_ready_o  out  1  block can accept a request.
- req_vaddr_i  in  VIRTUAL_ADDR_LEN  load byte address, from the AGU.
- req_size_i  in  2  0=byte, 1=half, 2=word, 3=double.
- req_unsigned_i  in  1  1=zero-extend, 0=sign-extend.
- req_rob_idx_i  in  ROB_INDEX_WIDTH  tag.
- mem_req_valid_o  out  1  memory read request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  VIRTUAL_ADDR_LEN  doubleword-aligned address, low 3 bits always 0.
- mem_resp_valid_i  in  1  read data valid; no backpressure.
- mem_resp_data_i  in  XLEN  aligned doubleword.
- wb_valid_o  out  1  merged result valid.
- wb_ready_i  in  1  consumer accepts result.
- wb_data_o  out  XLEN  right-justified, extended load value.
- wb_rob_idx_o  out  ROB_INDEX_WIDTH  tag of the result.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, WB. One load in flight.
- IDLE: req_ready_o=1. On req_valid_i, latch vaddr, size, unsigned, rob_idx; compute off=vaddr[2:0], nbytes=1<<size, split=(off+nbytes>8). Go to REQ0.
- REQ0: mem_req_valid_o=1, addr={vaddr[VA-1:3],3'b0}. On mem_req_ready_i -> WAIT0.
- WAIT0: on mem_resp_valid_i, latch data0; split ? REQ1 : WB.
- REQ1: addr = first addr + 8; wraps modulo 2^VIRTUAL_ADDR_LEN at the top of the address space. On mem_req_ready_i -> WAIT1.
- WAIT1: on mem_resp_valid_i, latch data1 -> WB.
- WB: wb_valid_o=1. On wb_ready_i -> IDLE.
- Merge: raw = split ? (data0 >> 8*off) | (data1 << 8*(8-off)) : data0 >> 8*off. Keep the low nbytes; bit 8*nbytes-1 is the sign bit. Zero- or sign-extend to XLEN. size=3 with unsigned ignores extension.
- mem_resp_valid_i outside WAIT0/WAIT1 is ignored; it is not an error output.
- Every output is a registered state decode or a latched value. There is no combinational path from any input to any output.

## Timing
- Reset: state=IDLE; req_ready_o=1; mem_req_valid_o=0; mem_req_addr_o=0; wb_valid_o=0; wb_data_o=0; wb_rob_idx_o=0. Asserting rstn=0 mid-transaction drops the load silently, with no writeback.
- Accept in cycle T -> mem_req_valid_o from T+1.
- Minimum latency with zero-wait memory and a single response one cycle after request: aligned load has wb_valid_o at T+3; split load at T+5.
- A response in the same cycle as its request handshake is not captured; memory returns data at least 1 cycle later.
- mem_req_valid_o/addr hold stable until mem_req_ready_i. wb_valid_o/data/tag hold until wb_ready_i.
- req_ready_o=0 in WB, including the handshake cycle. A new request is accepted at the earliest the cycle after the WB handshake (IDLE).

## Structure
- Shared package lsu_pkg: size encodings (LSU_SIZE_B/H/W/D) and the state enum.
- XLEN and VIRTUAL_ADDR_LEN come from the common params header.
- One combinational sub-module, lsu_ld_extend (inputs: raw, size, unsigned; output: extended XLEN value). It is reused by the store-forwarding path.
- The shifter and merge stay in the top module.

## Test plan
- Aligned byte: vaddr=0x1003, size=0, signed, resp=0x0000_0000_8000_0000 -> mem addr 0x1000 only; wb_data=0xFFFF_FFFF_FFFF_FF80.
- Split word: vaddr=0x2006, size=2, unsigned, resp0=0xBBAA_0000_0000_0000, resp1=0x0000_0000_0000_DDCC -> addrs 0x2000 then 0x2008; wb_data=0x0000_0000_DDCC_BBAA.
- Split double with wrap: vaddr=0x7F_FFFF_FFFF, size=3 -> second addr 0x0; merged value = resp0[63:56] | resp1[55:0]<<8.
- Backpressure: hold mem_req_ready_i=0 for 3 cycles, then wb_ready_i=0 for 2 cycles -> addr/data stable; exactly one wb handshake; req_ready_o=0 throughout.
- Spurious response in IDLE, plus rstn=0 while in WAIT1 -> no wb_valid_o; all outputs at reset values next cycle; a subsequent aligned load completes normally.
- Back-to-back: req_valid_i held high with 2 loads, zero-wait memory -> second accepted the cycle after the first WB handshake; tags returned in order.
